// File: rtl/ir_dispatch_if.sv
// Bus bundle for ir_dispatch: IR capture, diagnostic DRAM loader and dispatch outputs.
// master drives the instruction/diagnostic inputs; slave is the dispatch block.
interface ir_dispatch_if #(
  parameter int CHUNK = 6
);
  logic             load_ir;
  logic             mb_xfer;
  logic [0:12]      cache_data;
  logic [0:12]      ad;
  logic             diag_wr;
  logic [0:8]       diag_addr;
  logic [0:CHUNK-1] diag_data;
  logic             diag_abort;
  logic             par_clr;

  logic [0:12]      ir;
  logic [0:3]       ac;
  logic             jrst0;
  logic             io_legal;
  logic [0:2]       dram_a;
  logic [0:2]       dram_b;
  logic [1:10]      dram_j;
  logic             dram_valid;
  logic             dram_par_err;
  logic             diag_busy;

  modport master (
    output load_ir, mb_xfer, cache_data, ad, diag_wr, diag_addr, diag_data,
           diag_abort, par_clr,
    input  ir, ac, jrst0, io_legal, dram_a, dram_b, dram_j, dram_valid,
           dram_par_err, diag_busy
  );

  modport slave (
    input  load_ir, mb_xfer, cache_data, ad, diag_wr, diag_addr, diag_data,
           diag_abort, par_clr,
    output ir, ac, jrst0, io_legal, dram_a, dram_b, dram_j, dram_valid,
           dram_par_err, diag_busy
  );
endinterface

// File: rtl/ir_dispatch.sv
// EBOX instruction register and dispatch-RAM lookup with a chunked diagnostic DRAM loader.
// Optional feature macro IR_DRAM_PARITY_EN enables the sticky DRAM parity check.
module ir_dispatch #(
  parameter int DRAM_WIDTH = 15,
  parameter int DRAM_SIZE  = 512,
  parameter int CHUNK      = 6
) (
  input  logic         clk,
  input  logic         reset,
  ir_dispatch_if.slave bus
);

  localparam int NCHUNK = (DRAM_WIDTH + CHUNK - 1) / CHUNK;
  localparam int ACC_W  = NCHUNK * CHUNK;
  localparam int AW     = $clog2(DRAM_SIZE);
  localparam int CW     = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {IDLE, LOOK, HOLD} look_t;
  typedef enum logic [1:0] {LIDLE, LACC, LCOMMIT} load_t;

  look_t                 look_q, look_d;
  load_t                 load_q, load_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [0:ACC_W-1]      acc_q, acc_d;
  logic [0:8]            waddr_q, waddr_d;
  logic [0:12]           ir_q, ir_d;
  logic                  fresh_q, fresh_d;
  logic                  valid_q, valid_d;
  logic [0:2]            a_q, a_d;
  logic [0:2]            b_q, b_d;
  logic [1:10]           j_q, j_d;
  logic [0:DRAM_WIDTH-1] rdata_q;
  logic [0:DRAM_WIDTH-1] dram_mem [DRAM_SIZE];

  logic [0:8]            adr;
  logic [0:DRAM_WIDTH-1] wdata;
  logic                  wr_en, rd_en, wr_hit, jrst_op, par_set;

  // 7xx I/O opcodes fold the device field into the low dispatch bits
  always_comb begin
    adr[0:2] = ir_q[0:2];
    if (ir_q[0:2] == 3'b111) begin
      adr[3:5] = {3{|ir_q[3:6]}} | ir_q[7:9];
      adr[6:8] = ir_q[10:12];
    end else begin
      adr[3:8] = ir_q[3:8];
    end
  end

  assign jrst_op = (ir_q[0:8] == 9'o254);
  assign wr_en   = (load_q == LCOMMIT) && !reset;
  assign wr_hit  = wr_en && (waddr_q == adr);
  assign wdata   = acc_q[ACC_W-DRAM_WIDTH:ACC_W-1];

  // Loader: shift chunks MS-first, then commit one word
  always_comb begin
    load_d  = load_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    waddr_d = waddr_q;
    case (load_q)
      LIDLE: begin
        if (bus.diag_wr) begin
          waddr_d = bus.diag_addr;
          acc_d   = ACC_W'({acc_q, bus.diag_data});
          cnt_d   = CW'(1);
          load_d  = (NCHUNK == 1) ? LCOMMIT : LACC;
        end
      end
      LACC: begin
        if (bus.diag_abort) begin
          cnt_d  = '0;
          load_d = LIDLE;
        end else if (bus.diag_wr) begin
          acc_d = ACC_W'({acc_q, bus.diag_data});
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(NCHUNK)) load_d = LCOMMIT;
        end
      end
      default: begin
        cnt_d  = '0;
        load_d = LIDLE;
      end
    endcase
  end

  // Lookup: LOOK issues the read (yielding to a commit), HOLD registers the fields
  always_comb begin
    look_d  = look_q;
    ir_d    = ir_q;
    fresh_d = fresh_q;
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    j_d     = j_q;
    rd_en   = 1'b0;
    par_set = 1'b0;
    if (bus.load_ir) begin
      ir_d    = bus.mb_xfer ? bus.cache_data : bus.ad;
      look_d  = LOOK;
      fresh_d = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (look_q)
        LOOK: begin
          if (!wr_en) begin
            rd_en   = 1'b1;
            fresh_d = 1'b1;
            look_d  = HOLD;
          end
        end
        HOLD: begin
          if (wr_hit) begin
            look_d  = LOOK;
            fresh_d = 1'b0;
            valid_d = 1'b0;
          end else if (fresh_q) begin
            a_d     = rdata_q[0:2];
            b_d     = rdata_q[3:5];
            j_d     = {rdata_q[7:10], 2'b00, jrst_op ? ir_q[9:12] : rdata_q[11:14]};
            par_set = ~^rdata_q[0:14];
            fresh_d = 1'b0;
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      look_q  <= IDLE;
      load_q  <= LIDLE;
      cnt_q   <= '0;
      ir_q    <= '0;
      fresh_q <= 1'b0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      j_q     <= '0;
    end else begin
      look_q  <= look_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      fresh_q <= fresh_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      j_q     <= j_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    waddr_q <= waddr_d;
  end

  // Single-port DRAM: a committing write takes the port from the lookup read
  always_ff @(posedge clk) begin
    if (wr_en) dram_mem[AW'(waddr_q)] <= wdata;
    else if (rd_en) rdata_q <= dram_mem[AW'(adr)];
  end

`ifdef IR_DRAM_PARITY_EN
  logic par_err_q, par_err_d;

  always_comb par_err_d = par_set | (par_err_q & ~bus.par_clr);

  always_ff @(posedge clk) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end

  assign bus.dram_par_err = par_err_q;
`else
  assign bus.dram_par_err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{rdata_q, par_set, bus.par_clr};

  assign bus.ir         = ir_q;
  assign bus.ac         = ir_q[9:12];
  assign bus.jrst0      = jrst_op && (ir_q[9:12] == 4'd0);
  assign bus.io_legal   = &ir_q[3:6];
  assign bus.dram_a     = a_q;
  assign bus.dram_b     = b_q;
  assign bus.dram_j     = j_q;
  assign bus.dram_valid = valid_q;
  assign bus.diag_busy  = (load_q != LIDLE);

endmodule

// File: tb/tb_ir_dispatch.sv
// Directed bench for ir_dispatch: table of IR lookups plus loader/collision/parity/reset sequences.
module tb_ir_dispatch;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ir_dispatch_if #(.CHUNK(6)) bus ();

  ir_dispatch #(.DRAM_WIDTH(15), .DRAM_SIZE(512), .CHUNK(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

`ifdef IR_DRAM_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        mb;
    logic [12:0] instr;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [9:0]  j;
    logic        jr;
    logic        io;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A,B,P,J[1:4],J[7:10] packed MS-first; P makes the 15 bits odd
  function automatic logic [17:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [3:0] j14, input logic [3:0] j710);
    return {3'b000, a, b, ~^{a, b, j14, j710}, j14, j710};
  endfunction

  task automatic diag_load(input logic [8:0] addr, input logic [17:0] w);
    bus.diag_addr = addr;
    for (int i = 0; i < 3; i++) begin
      bus.diag_wr   = 1'b1;
      bus.diag_data = w[17-6*i -: 6];
      step();
    end
    bus.diag_wr = 1'b0;
    step();
  endtask

  task automatic lookup(input logic [12:0] instr);
    bus.mb_xfer = 1'b0;
    bus.ad      = instr;
    bus.load_ir = 1'b1;
    step();
    bus.load_ir = 1'b0;
    step();
    step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ir"}, bus.ir, 0);
    chk({tag, "_ac"}, bus.ac, 0);
    chk({tag, "_jrst0"}, bus.jrst0, 0);
    chk({tag, "_io_legal"}, bus.io_legal, 0);
    chk({tag, "_a"}, bus.dram_a, 0);
    chk({tag, "_b"}, bus.dram_b, 0);
    chk({tag, "_j"}, bus.dram_j, 0);
    chk({tag, "_valid"}, bus.dram_valid, 0);
    chk({tag, "_par"}, bus.dram_par_err, 0);
    chk({tag, "_busy"}, bus.diag_busy, 0);
  endtask

  initial begin
    tv[0] = '{1'b0, 13'b010_000_000_0000, 3'd3, 3'd5, 10'b1010_00_0011, 1'b0, 1'b0};
    tv[1] = '{1'b1, 13'b010_000_000_0111, 3'd3, 3'd5, 10'b1010_00_0011, 1'b0, 1'b0};
    tv[2] = '{1'b0, 13'b010_101_100_0101, 3'd1, 3'd2, 10'b0110_00_0101, 1'b0, 1'b0};
    tv[3] = '{1'b1, 13'b010_101_100_0000, 3'd1, 3'd2, 10'b0110_00_0000, 1'b1, 1'b0};
    tv[4] = '{1'b0, 13'b111_0001_010_110, 3'd7, 3'd1, 10'b0001_00_0010, 1'b0, 1'b0};
    tv[5] = '{1'b0, 13'b111_0000_010_110, 3'd2, 3'd6, 10'b1100_00_1001, 1'b0, 1'b0};
    tv[6] = '{1'b1, 13'b111_1111_000_000, 3'd4, 3'd4, 10'b0101_00_0110, 1'b0, 1'b1};

    reset = 1'b1;
    bus.load_ir = 1'b0; bus.mb_xfer = 1'b0; bus.cache_data = '0; bus.ad = '0;
    bus.diag_wr = 1'b0; bus.diag_addr = '0; bus.diag_data = '0;
    bus.diag_abort = 1'b0; bus.par_clr = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_reset("rst0");

    diag_load(9'o200, mk(3'd3, 3'd5, 4'hA, 4'h3));
    diag_load(9'o254, mk(3'd1, 3'd2, 4'h6, 4'hF));
    diag_load(9'o776, mk(3'd7, 3'd1, 4'h1, 4'h2));
    diag_load(9'o726, mk(3'd2, 3'd6, 4'hC, 4'h9));
    diag_load(9'o770, mk(3'd4, 3'd4, 4'h5, 4'h6));

    for (int k = 0; k < 7; k++) begin
      bus.mb_xfer    = tv[k].mb;
      bus.ad         = tv[k].mb ? ~tv[k].instr : tv[k].instr;
      bus.cache_data = tv[k].mb ? tv[k].instr : ~tv[k].instr;
      bus.load_ir    = 1'b1;
      step();
      bus.load_ir = 1'b0;
      chk($sformatf("v%0d_ir", k), bus.ir, tv[k].instr);
      chk($sformatf("v%0d_ac", k), bus.ac, tv[k].instr[3:0]);
      chk($sformatf("v%0d_jrst0", k), bus.jrst0, tv[k].jr);
      chk($sformatf("v%0d_io_legal", k), bus.io_legal, tv[k].io);
      chk($sformatf("v%0d_valid_n", k), bus.dram_valid, 0);
      step();
      chk($sformatf("v%0d_valid_n1", k), bus.dram_valid, 0);
      step();
      chk($sformatf("v%0d_valid_n2", k), bus.dram_valid, 1);
      chk($sformatf("v%0d_a", k), bus.dram_a, tv[k].a);
      chk($sformatf("v%0d_b", k), bus.dram_b, tv[k].b);
      chk($sformatf("v%0d_j", k), bus.dram_j, tv[k].j);
      chk($sformatf("v%0d_par", k), bus.dram_par_err, 0);
    end

    // Load to 0o040 with load_ir alongside the last chunk: the read collides with the commit
    bus.diag_addr = 9'o040;
    bus.diag_wr   = 1'b1;
    bus.diag_data = 6'o07;
    step();
    chk("coll_busy1", bus.diag_busy, 1);
    bus.diag_data = 6'o52;
    step();
    bus.diag_data = 6'o31;
    bus.mb_xfer   = 1'b0;
    bus.ad        = 13'b000_100_000_0000;
    bus.load_ir   = 1'b1;
    step();
    bus.load_ir   = 1'b0;
    bus.diag_data = 6'o77;
    chk("coll_busy_commit", bus.diag_busy, 1);
    chk("coll_valid1", bus.dram_valid, 0);
    step();
    bus.diag_wr = 1'b0;
    chk("coll_wr_ignored", bus.diag_busy, 0);
    chk("coll_valid2", bus.dram_valid, 0);
    step();
    chk("coll_valid3", bus.dram_valid, 0);
    step();
    chk("coll_valid4", bus.dram_valid, 1);
    chk("coll_a", bus.dram_a, 3'd7);
    chk("coll_b", bus.dram_b, 3'd5);
    chk("coll_j", bus.dram_j, 10'b1001_00_1001);

    // Writes while holding 0o040: elsewhere keeps valid, same address forces a re-read
    diag_load(9'o300, mk(3'd6, 3'd6, 4'h1, 4'h1));
    chk("hold_other_valid", bus.dram_valid, 1);
    diag_load(9'o040, mk(3'd2, 3'd3, 4'h5, 4'h6));
    chk("hit_valid0", bus.dram_valid, 0);
    step();
    chk("hit_valid1", bus.dram_valid, 0);
    step();
    chk("hit_valid2", bus.dram_valid, 1);
    chk("hit_a", bus.dram_a, 3'd2);
    chk("hit_b", bus.dram_b, 3'd3);
    chk("hit_j", bus.dram_j, 10'b0101_00_0110);

    // Even-parity word at 0o100 (P flipped)
    diag_load(9'o100, mk(3'd1, 3'd0, 4'h0, 4'h0) ^ 18'o000400);
    lookup(13'b001_000_000_0000);
    chk("par_valid", bus.dram_valid, 1);
    chk("par_a", bus.dram_a, 3'd1);
    chk("par_set", bus.dram_par_err, PAR_EN);
    lookup(13'b010_000_000_0000);
    chk("par_sticky_a", bus.dram_a, 3'd3);
    chk("par_sticky", bus.dram_par_err, PAR_EN);
    bus.par_clr = 1'b1;
    step();
    bus.par_clr = 1'b0;
    chk("par_clr", bus.dram_par_err, 0);
    bus.ad      = 13'b001_000_000_0000;
    bus.load_ir = 1'b1;
    step();
    bus.load_ir = 1'b0;
    step();
    bus.par_clr = 1'b1;
    step();
    bus.par_clr = 1'b0;
    chk("par_set_wins_valid", bus.dram_valid, 1);
    chk("par_set_wins", bus.dram_par_err, PAR_EN);
    bus.par_clr = 1'b1;
    step();
    bus.par_clr = 1'b0;
    chk("par_clr2", bus.dram_par_err, 0);

    // Abort after two chunks, then reset mid-load: 0o200 must keep its contents
    bus.diag_addr = 9'o200;
    bus.diag_wr   = 1'b1;
    bus.diag_data = 6'o77;
    step();
    step();
    bus.diag_wr    = 1'b0;
    bus.diag_abort = 1'b1;
    step();
    bus.diag_abort = 1'b0;
    chk("abort_busy", bus.diag_busy, 0);
    lookup(13'b010_000_000_0000);
    chk("abort_a", bus.dram_a, 3'd3);
    chk("abort_b", bus.dram_b, 3'd5);
    bus.diag_wr   = 1'b1;
    bus.diag_data = 6'o77;
    step();
    step();
    bus.diag_wr = 1'b0;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    chk_reset("rst_mid");
    lookup(13'b010_000_000_0000);
    chk("rst_keep_valid", bus.dram_valid, 1);
    chk("rst_keep_a", bus.dram_a, 3'd3);
    chk("rst_keep_j", bus.dram_j, 10'b1010_00_0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
